// File: rtl/camera_pattern_source_if.sv
//============================================================================
// Module   : camera_pattern_source_if
// Brief    : Control inputs and OV7670-style output bus of the pattern source.
// Revision : 1.0
//============================================================================
`default_nettype none

interface camera_pattern_source_if;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [15:0] color;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic [15:0] frame_sum;

    modport master (
        input  en, pattern_sel, color,
        output vsync, href, d, frame_done, frame_cnt, frame_sum
    );

    modport slave (
        output en, pattern_sel, color,
        input  vsync, href, d, frame_done, frame_cnt, frame_sum
    );
endinterface

`default_nettype wire

// File: rtl/camera_pattern_source.sv
//============================================================================
// Module   : camera_pattern_source
// Brief    : Synthetic camera emitting RGB565 test frames; CAM_SRC_CHECKSUM_EN
//            adds a per-frame byte checksum on FRAME_SUM.
// Revision : 1.0
//============================================================================
`default_nettype none

module camera_pattern_source #(
    parameter int H_ACTIVE    = 176,
    parameter int V_ACTIVE    = 144,
    parameter int H_BLANK     = 32,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    camera_pattern_source_if.master   cam
);
    localparam int L     = 2 * H_ACTIVE + H_BLANK;
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    localparam logic [15:0] c_l_last   = 16'(L - 1);
    localparam logic [15:0] c_act_last = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] c_hb_last  = 16'(H_BLANK - 1);
    localparam logic [15:0] c_y_last   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] c_vs_last  = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] c_vb_last  = 16'(V_BACK - 1);
    localparam logic [15:0] c_vf_last  = 16'(V_FRONT - 1);
    localparam logic [15:0] c_bar_w    = 16'(BAR_W);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SYNC   = 3'd1;
    localparam logic [2:0] c_ST_BACK   = 3'd2;
    localparam logic [2:0] c_ST_ACTIVE = 3'd3;
    localparam logic [2:0] c_ST_HBLANK = 3'd4;
    localparam logic [2:0] c_ST_FRONT  = 3'd5;

    logic [2:0]  r_state;
    logic [15:0] r_col;
    logic [15:0] r_line;
    logic [15:0] r_y;
    logic [1:0]  r_sel;
    logic [15:0] r_color;

    logic        r_vsync;
    logic        r_href;
    logic [7:0]  r_d;
    logic        r_done;
    logic [7:0]  r_frame_cnt;

    logic [15:0] w_lines_last;
    logic        w_period_end;
    logic        w_frame_end;
    logic        w_enter_sync;
    logic        w_active;
    logic [2:0]  w_next_blank;
    logic [15:0] w_x;
    logic [15:0] w_bar;
    logic [2:0]  w_bar_idx;
    logic [7:0]  w_grey;
    logic [15:0] w_pixel;
    logic [7:0]  w_byte;

    always_comb begin
        w_lines_last = c_vf_last;
        w_next_blank = cam.en ? c_ST_SYNC : c_ST_IDLE;
        case (r_state)
            c_ST_SYNC: begin
                w_lines_last = c_vs_last;
                w_next_blank = c_ST_BACK;
            end
            c_ST_BACK: begin
                w_lines_last = c_vb_last;
                w_next_blank = c_ST_ACTIVE;
            end
            default: ;
        endcase
    end

    assign w_period_end = (r_col == c_l_last) && (r_line == w_lines_last);
    assign w_frame_end  = (r_state == c_ST_FRONT) && w_period_end;
    assign w_enter_sync = cam.en && ((r_state == c_ST_IDLE) || w_frame_end);
    assign w_active     = (r_state == c_ST_ACTIVE);

    // Pixel generation runs one clock ahead of the registered byte bus.
    assign w_x       = {1'b0, r_col[15:1]};
    assign w_bar     = w_x / c_bar_w;
    assign w_bar_idx = (w_bar > 16'd7) ? 3'd7 : w_bar[2:0];
    assign w_grey    = w_x[7:0];

    always_comb begin
        w_pixel = r_color;
        case (r_sel)
            2'd1: begin
                case (w_bar_idx)
                    3'd0:    w_pixel = 16'hFFFF;
                    3'd1:    w_pixel = 16'hFFE0;
                    3'd2:    w_pixel = 16'h07FF;
                    3'd3:    w_pixel = 16'h07E0;
                    3'd4:    w_pixel = 16'hF81F;
                    3'd5:    w_pixel = 16'hF800;
                    3'd6:    w_pixel = 16'h001F;
                    default: w_pixel = 16'h0000;
                endcase
            end
            2'd2:    w_pixel = {w_grey[7:3], w_grey[7:2], w_grey[7:3]};
            2'd3:    w_pixel = (w_x[3] ^ r_y[3]) ? 16'hFFFF : 16'h0000;
            default: w_pixel = r_color;
        endcase
    end

    assign w_byte = r_col[0] ? w_pixel[7:0] : w_pixel[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_col   <= 16'd0;
            r_line  <= 16'd0;
            r_y     <= 16'd0;
            r_sel   <= 2'd0;
            r_color <= 16'd0;
        end else begin
            if (w_enter_sync) begin
                r_sel   <= cam.pattern_sel;
                r_color <= cam.color;
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_col  <= 16'd0;
                    r_line <= 16'd0;
                    if (cam.en) r_state <= c_ST_SYNC;
                end
                c_ST_SYNC, c_ST_BACK, c_ST_FRONT: begin
                    r_y <= 16'd0;
                    if (r_col == c_l_last) begin
                        r_col  <= 16'd0;
                        r_line <= w_period_end ? 16'd0 : r_line + 16'd1;
                    end else begin
                        r_col <= r_col + 16'd1;
                    end
                    if (w_period_end) r_state <= w_next_blank;
                end
                c_ST_ACTIVE: begin
                    if (r_col == c_act_last) begin
                        r_col   <= 16'd0;
                        r_state <= c_ST_HBLANK;
                    end else begin
                        r_col <= r_col + 16'd1;
                    end
                end
                c_ST_HBLANK: begin
                    if (r_col == c_hb_last) begin
                        r_col <= 16'd0;
                        if (r_y == c_y_last) begin
                            r_state <= c_ST_FRONT;
                        end else begin
                            r_y     <= r_y + 16'd1;
                            r_state <= c_ST_ACTIVE;
                        end
                    end else begin
                        r_col <= r_col + 16'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_d         <= 8'h00;
            r_done      <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_vsync <= (r_state == c_ST_SYNC);
            r_href  <= w_active;
            r_d     <= w_active ? w_byte : 8'h00;
            r_done  <= w_frame_end;
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign cam.vsync      = r_vsync;
    assign cam.href       = r_href;
    assign cam.d          = r_d;
    assign cam.frame_done = r_done;
    assign cam.frame_cnt  = r_frame_cnt;

`ifdef CAM_SRC_CHECKSUM_EN
    logic [15:0] r_acc;
    logic [15:0] r_frame_sum;

    // Frame-end and SYNC entry can share an edge: FRAME_SUM takes the old total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= 16'd0;
            r_frame_sum <= 16'd0;
        end else begin
            if (w_enter_sync)  r_acc <= 16'd0;
            else if (w_active) r_acc <= r_acc + {8'h00, w_byte};
            if (w_frame_end)   r_frame_sum <= r_acc;
        end
    end

    assign cam.frame_sum = r_frame_sum;
`else
    assign cam.frame_sum = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_camera_pattern_source.sv
//============================================================================
// Module   : tb_camera_pattern_source
// Brief    : Self-checking bench for camera_pattern_source (small frame size).
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_camera_pattern_source;
    localparam int TH  = 8;
    localparam int TV  = 2;
    localparam int THB = 4;
    localparam int TVS = 1;
    localparam int TVB = 1;
    localparam int TVF = 1;
    localparam int TL  = 2 * TH + THB;
    localparam int TF  = (TVS + TVB + TV + TVF) * TL;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   last_rise;
    logic [7:0] exp_cnt;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    camera_pattern_source_if cam_if ();

    camera_pattern_source #(
        .H_ACTIVE(TH), .V_ACTIVE(TV), .H_BLANK(THB),
        .VSYNC_LINES(TVS), .V_BACK(TVB), .V_FRONT(TVF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cam (cam_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [15:0] pixel(input int x, input int y,
                                          input logic [1:0] sel, input logic [15:0] color);
        int b;
        int g;
        case (sel)
            2'd0: return color;
            2'd1: begin
                b = x / (TH / 8);
                if (b > 7) b = 7;
                return bars[b];
            end
            2'd2: begin
                g = x % 256;
                return 16'(((g >> 3) << 11) | ((g >> 2) << 5) | (g >> 3));
            end
            default: return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Expected {vsync, href, d, frame_done} at clock t of a frame (t=0: first VSYNC clock).
    function automatic logic [10:0] exp_vec(input int t, input logic [1:0] sel,
                                            input logic [15:0] color);
        logic        vs;
        logic        hr;
        logic [7:0]  d;
        logic [15:0] p;
        int a0;
        int k;
        vs = (t < TVS * TL);
        hr = 1'b0;
        d  = 8'h00;
        a0 = (TVS + TVB) * TL;
        if (t >= a0 && t < a0 + TV * TL) begin
            k = (t - a0) % TL;
            if (k < 2 * TH) begin
                hr = 1'b1;
                p  = pixel(k / 2, (t - a0) / TL, sel, color);
                d  = (k % 2 == 1) ? p[7:0] : p[15:8];
            end
        end
        return {vs, hr, d, (t == TF - 1)};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {cam_if.vsync, cam_if.href, cam_if.d, cam_if.frame_done};
    endfunction

    // One full frame checked clock by clock; inputs for the next frame are presented at sw_t.
    task automatic run_frame(input logic [1:0] sel, input logic [15:0] color, input int sw_t,
                             input logic nen, input logic [1:0] nsel, input logic [15:0] ncolor);
        logic [10:0] e;
        logic [15:0] sum;
        sum = 16'd0;
        for (int t = 0; t < TF; t++) begin
            @(negedge clk);
            if (t == 0) begin
                if (last_rise >= 0) check("vsync_period", 32'(cyc - last_rise), 32'(TF));
                last_rise = cyc;
            end
            e = exp_vec(t, sel, color);
            check($sformatf("frame_t%0d_sel%0d", t, sel), 32'(obs_vec()), 32'(e));
            if (e[9]) sum = sum + 16'(e[8:1]);
            if (t == sw_t) begin
                cam_if.en          = nen;
                cam_if.pattern_sel = nsel;
                cam_if.color       = ncolor;
            end
            if (t == TF - 1) begin
                exp_cnt = exp_cnt + 8'd1;
                check("frame_cnt", 32'(cam_if.frame_cnt), 32'(exp_cnt));
`ifdef CAM_SRC_CHECKSUM_EN
                check("frame_sum", 32'(cam_if.frame_sum), 32'(sum));
`else
                check("frame_sum", 32'(cam_if.frame_sum), 32'(sum & 16'h0000));
`endif
            end
        end
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_bus", 32'(obs_vec()), 32'd0);
            check("idle_cnt", 32'(cam_if.frame_cnt), 32'(exp_cnt));
        end
    endtask

    // EN is driven at a falling edge; the bus stays quiet for the clock after the start edge.
    task automatic start(input logic [1:0] sel, input logic [15:0] color);
        cam_if.en          = 1'b1;
        cam_if.pattern_sel = sel;
        cam_if.color       = color;
        @(negedge clk);
        check("start_latency", 32'(obs_vec()), 32'd0);
    endtask

    initial begin
        logic [1:0]  s;
        logic [1:0]  ns;
        logic [15:0] c;
        logic [15:0] nc;
        int          nframes;
        n_checks  = 0;
        n_pass    = 0;
        last_rise = -1;
        exp_cnt   = 8'd0;
        rst       = 1'b1;
        cam_if.en          = 1'b0;
        cam_if.pattern_sel = 2'd0;
        cam_if.color       = 16'd0;

        repeat (3) @(negedge clk);
        check("rst_vsync", 32'(cam_if.vsync), 32'd0);
        check("rst_href", 32'(cam_if.href), 32'd0);
        check("rst_d", 32'(cam_if.d), 32'd0);
        check("rst_done", 32'(cam_if.frame_done), 32'd0);
        check("rst_cnt", 32'(cam_if.frame_cnt), 32'd0);
        check("rst_sum", 32'(cam_if.frame_sum), 32'd0);
        rst = 1'b0;
        check_idle(2);

        // Solid F81F, then colour bars, with junk on the inputs mid-frame.
        start(2'd0, 16'hF81F);
        run_frame(2'd0, 16'hF81F, 60, 1'b1, 2'd1, 16'($urandom));
        c = 16'($urandom);
        run_frame(2'd1, 16'hF81F, 60, 1'b1, 2'd2, c);
        s = 2'd2;
        for (int i = 0; i < 4; i++) begin
            ns = 2'($urandom_range(0, 3));
            nc = 16'($urandom);
            run_frame(s, c, 60, 1'b1, ns, nc);
            s = ns;
            c = nc;
        end

        // EN dropped in the first active line: frame completes then stays idle.
        run_frame(s, c, 45, 1'b0, 2'($urandom), 16'($urandom));
        check_idle(30);
        last_rise = -1;

        // Free-running frames until FRAME_CNT wraps to 0.
        s = 2'($urandom_range(0, 3));
        c = 16'($urandom);
        start(s, c);
        nframes = 256 - int'(exp_cnt);
        for (int i = 0; i < nframes; i++) begin
            ns = 2'($urandom_range(0, 3));
            nc = 16'($urandom);
            run_frame(s, c, 60, 1'b1, ns, nc);
            s = ns;
            c = nc;
        end
        check("cnt_wrapped", 32'(cam_if.frame_cnt), 32'd0);

        // Reset asserted while HREF is high; outputs clear without waiting for a clock.
        for (int t = 0; t <= (TVS + TVB) * TL + 1; t++) @(negedge clk);
        check("href_before_rst", 32'(cam_if.href), 32'd1);
        #1 rst = 1'b1;
        cam_if.en = 1'b0;
        #1;
        check("rst_async_bus", 32'(obs_vec()), 32'd0);
        check("rst_async_cnt", 32'(cam_if.frame_cnt), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        exp_cnt   = 8'd0;
        last_rise = -1;
        check_idle(3);

        s = 2'($urandom_range(0, 3));
        c = 16'($urandom);
        start(s, c);
        run_frame(s, c, 50, 1'b0, 2'd0, 16'd0);
        check_idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
